ofifo_col_align: RTL and testbench
==================================

Name: ofifo_col_align

Overview:
- Output-side collection stage directly downstream of the mac_col array.
- Each mac_col lane writes its bw_psum-wide psum when its fifo_wr strobe pulses. Columns fire on staggered cycles, one cycle apart per col_id.
- This block holds one small FIFO per lane and pops them together as one aligned row of col psums.
- The row goes to the SFU/accumulator stage or to the output SRAM writer.

Parameters:
- col, 8, number of lanes (mac_col instances).
- bw_psum, 19, psum width per lane (2*8+3).
- depth, 16, entries per lane FIFO; must be a power of two.
- depth_log2, 4, log2(depth); pointer width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- wr  input  col  per-lane write strobe; wr[k] comes from mac_col k fifo_wr.
- in  input  col*bw_psum  lane k psum at [(k+1)*bw_psum-1 : k*bw_psum], signed.
- rd  input  1  pop-row request.
- out  output  col*bw_psum  registered popped row; same lane packing as in.
- o_valid  output  1  every lane FIFO non-empty (a row is available).
- o_full  output  1  at least one lane FIFO full.
- o_overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset values (reset==0, asynchronous): all write/read pointers 0, all lane counts 0, out=0, o_overflow=0. Therefore o_valid=0 and o_full=0. FIFO storage is not reset.
- Per lane k, independent state: wptr[k] and rptr[k] (depth_log2 bits, wrap mod depth) and cnt[k] (depth_log2+1 bits, range 0..depth).
- Pop: pop = rd & o_valid.
- Write acceptance: lane k accepts a write when wr[k] & (cnt[k]<depth | pop).
  - An accepted write stores in[k] at wptr[k] and increments wptr[k].
  - Writing to a full lane in the same cycle as a pop is accepted; the count is unchanged.
- Dropped write: wr[k] & cnt[k]==depth & !pop.
  - The entry is discarded, pointers are unchanged, and o_overflow is set at the next edge.
  - o_overflow stays set until reset.
- Pop behaviour: on pop, every lane reads entry rptr[k] into out lane k at the clock edge, and every rptr[k] increments.
  - Read latency is 1 cycle: data appears on out the cycle after rd is sampled with o_valid=1.
- rd while o_valid=0 is ignored: no pointer change, out holds.
- out holds its value between pops.
- Count update per lane: cnt[k] += accepted_write[k] - pop.
- o_valid = AND over k of (cnt[k]!=0). o_full = OR over k of (cnt[k]==depth). Both are decoded from registered counts; no combinational path from wr, rd or in.
- A write and a pop on an empty lane in the same cycle: the pop cannot occur, because o_valid requires that lane non-empty. Same-cycle write-through is never performed.
- Staggered fill: a row becomes valid only once the slowest lane has written. Extra writes on early lanes queue up to depth.
- Pointer wrap: wptr/rptr wrap from depth-1 to 0. With depth=16, cnt reaches 16 with wptr==rptr.
- Reset asserted mid-operation: all queued data is discarded immediately (asynchronous clear). No output glitches other than the drop to reset values.
- Storage uses plain registers. The memory array is written synchronously only.

Optional Feature:
- Macro: OFIFO_RELU_EN.
- Defined: each lane value is passed through ReLU when loaded into out on pop. Negative (MSB=1) lanes become 0; non-negative lanes pass unchanged. Latency is unchanged.
- Not defined: out carries stored psums unmodified, including negative values.

Test Plan:
- Reset check: hold reset=0, then release. Expect out=0, o_valid=0, o_full=0, o_overflow=0. Pulse rd=1 with all lanes empty; expect no change.
- Staggered fill: pulse wr[k] at cycle 10+k with lane value 100+k. o_valid rises only the cycle after wr[7]. With rd=1, out lanes 0..7 equal 100..107 one cycle later, and o_valid then drops to 0.
- Full and overflow: write 16 entries (values 0..15) to every lane, then o_full=1. A 17th wr on lane 3 with rd=0 sets o_overflow=1. Sixteen pops then return 0..15 in order on every lane, with no 17th value.
- Full with simultaneous pop: with all lanes full, assert rd=1 and wr=8'hFF with value 55 in the same cycle. o_full stays 1, o_overflow stays 0, and value 55 is popped as the 16th row afterwards.
- Wrap-around: run 40 write/pop cycles at occupancy 1..3. out sequence matches the write sequence with no gaps across the pointer wrap at 16.
- ReLU: lane 2 = -5 (19'h7FFFB), lane 0 = 7, pop. With OFIFO_RELU_EN, out lane 2 = 0 and lane 0 = 7. Without it, out lane 2 = 19'h7FFFB.

Source files
------------

// File: rtl/ofifo_col_align.sv
// Output-side collector for the mac_col array: one small FIFO per lane, popped together as an aligned row.
// Optional OFIFO_RELU_EN clamps negative lane values to zero as they are loaded into out.
module ofifo_col_align_lane #(
  parameter int bw_psum    = 19,
  parameter int depth      = 16,
  parameter int depth_log2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               pop,
  input  logic [bw_psum-1:0] din,
  output logic [bw_psum-1:0] dout,
  output logic               nonempty,
  output logic               full,
  output logic               drop
);
  localparam logic [depth_log2:0] FULL_CNT = (depth_log2+1)'(depth);
  localparam logic [depth_log2:0] ONE      = (depth_log2+1)'(1);

  logic [bw_psum-1:0]    mem [depth];
  logic [depth_log2-1:0] wptr, rptr;
  logic [depth_log2:0]   cnt;
  logic                  accept;
  logic [bw_psum-1:0]    rd_data, load_val;

  assign full     = (cnt == FULL_CNT);
  assign nonempty = (cnt != '0);
  // A full lane may still take a write when the row pops in the same cycle.
  assign accept   = wr & (~full | pop);
  assign drop     = wr & full & ~pop;
  assign rd_data  = mem[rptr];

`ifdef OFIFO_RELU_EN
  assign load_val = rd_data[bw_psum-1] ? '0 : rd_data;
`else
  assign load_val = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        dout <= load_val;
      end
      case ({accept, pop})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: ;
      endcase
    end
  end
endmodule

module ofifo_col_align #(
  parameter int col        = 8,
  parameter int bw_psum    = 19,
  parameter int depth      = 16,
  parameter int depth_log2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr,
  input  logic [col*bw_psum-1:0]   in,
  input  logic                     rd,
  output logic [col*bw_psum-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_overflow
);
  logic [col-1:0][bw_psum-1:0] row_in, row_out;
  logic [col-1:0]              lane_nonempty, lane_full, lane_drop;
  logic                        pop;

  assign row_in     = in;
  assign out        = row_out;
  // Flags decode registered lane counts only; no path from wr/rd/in.
  assign o_valid    = &lane_nonempty;
  assign o_full     = |lane_full;
  assign pop        = rd & o_valid;

  for (genvar k = 0; k < col; k++) begin : g_lane
    ofifo_col_align_lane #(
      .bw_psum   (bw_psum),
      .depth     (depth),
      .depth_log2(depth_log2)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[k]),
      .pop     (pop),
      .din     (row_in[k]),
      .dout    (row_out[k]),
      .nonempty(lane_nonempty[k]),
      .full    (lane_full[k]),
      .drop    (lane_drop[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          o_overflow <= 1'b0;
    else if (|lane_drop) o_overflow <= 1'b1;
  end
endmodule

// File: tb/tb_ofifo_col_align.sv
// Scoreboard bench for ofifo_col_align: stimulus queues expected rows, a negedge monitor checks each pop.
module tb_ofifo_col_align;
  localparam int COL = 8;
  localparam int BW  = 19;
  localparam int RW  = COL*BW;

  logic          clk = 1'b0;
  logic          reset;
  logic [COL-1:0] wr;
  logic [RW-1:0] in;
  logic          rd;
  logic [RW-1:0] out;
  logic          o_valid, o_full, o_overflow;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic          pend = 1'b0;

  ofifo_col_align dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row_seq(input int v);
    logic [RW-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(v + 1000*k);
    return r;
  endfunction

  function automatic logic [RW-1:0] row_const(input int v);
    logic [RW-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge rd/o_valid show the upcoming pop.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!reset) pend = 1'b0;
    else begin
      if (pend) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected actual=%h required=no_pop", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            failures++;
            $display("FAIL row_data actual=%h required=%h", out, e);
          end
        end
      end
      pend = rd && o_valid;
    end
  end

  initial begin
    logic [RW-1:0] r, rexp;
    reset = 1'b0; wr = '0; in = '0; rd = 1'b0;
    repeat (3) step();
    chk("rst_out_held", out, '0);
    reset = 1'b1;
    step();
    chk("rst_out", out, '0);
    chk("rst_valid", RW'(o_valid), '0);
    chk("rst_full", RW'(o_full), '0);
    chk("rst_ovf", RW'(o_overflow), '0);
    rd = 1'b1; step(); rd = 1'b0;
    chk("empty_rd_out", out, '0);
    chk("empty_rd_valid", RW'(o_valid), '0);

    // Staggered fill: lane k writes 100+k one cycle after lane k-1.
    r = '0;
    for (int k = 0; k < COL; k++) begin
      wr = COL'(1) << k;
      in = '0;
      in[k*BW +: BW] = BW'(100 + k);
      r[k*BW +: BW]  = BW'(100 + k);
      if (k < COL-1) begin
        step();
        chk($sformatf("stagger_valid_low_%0d", k), RW'(o_valid), '0);
      end else step();
    end
    wr = '0;
    chk("stagger_valid_high", RW'(o_valid), RW'(1));
    rd = 1'b1; exp_q.push_back(r); step(); rd = 1'b0;
    chk("stagger_valid_drop", RW'(o_valid), '0);

    // Fill to full, then a dropped write on lane 3.
    for (int i = 0; i < 16; i++) begin
      wr = '1; in = row_seq(i); step();
    end
    wr = '0;
    chk("fill_full", RW'(o_full), RW'(1));
    chk("fill_valid", RW'(o_valid), RW'(1));
    chk("fill_ovf_clear", RW'(o_overflow), '0);
    wr = 8'h08; in = row_seq(99); step(); wr = '0;
    chk("ovf_set", RW'(o_overflow), RW'(1));
    chk("ovf_still_full", RW'(o_full), RW'(1));
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1; exp_q.push_back(row_seq(i)); step();
      if (i == 0) chk("full_drop_after_pop", RW'(o_full), '0);
    end
    rd = 1'b0;
    chk("drain_valid", RW'(o_valid), '0);
    chk("ovf_sticky", RW'(o_overflow), RW'(1));
    rd = 1'b1; step(); rd = 1'b0;

    // Asynchronous reset clears the sticky flag without a clock edge.
    reset = 1'b0; #2;
    chk("async_rst_ovf", RW'(o_overflow), '0);
    chk("async_rst_out", out, '0);
    step(); reset = 1'b1; step();

    // Full lane written in the same cycle as a pop.
    for (int i = 0; i < 16; i++) begin
      wr = '1; in = row_seq(300 + i); step();
    end
    rd = 1'b1; wr = '1; in = row_const(55);
    exp_q.push_back(row_seq(300)); step();
    wr = '0;
    chk("fullpop_full", RW'(o_full), RW'(1));
    chk("fullpop_ovf", RW'(o_overflow), '0);
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back(row_seq(300 + i)); step();
    end
    exp_q.push_back(row_const(55)); step();
    rd = 1'b0;
    chk("fullpop_empty", RW'(o_valid), '0);

    // Wrap-around: steady write+pop at occupancy 2 across several pointer wraps.
    rd = 1'b0; wr = '1;
    in = row_seq(500); step();
    in = row_seq(501); step();
    for (int i = 0; i < 40; i++) begin
      in = row_seq(502 + i); rd = 1'b1;
      exp_q.push_back(row_seq(500 + i)); step();
    end
    wr = '0;
    exp_q.push_back(row_seq(540)); step();
    exp_q.push_back(row_seq(541)); step();
    rd = 1'b0;
    chk("wrap_empty", RW'(o_valid), '0);

    // Sign handling on negative lanes.
    r = row_const(0);
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(k);
    r[0*BW +: BW] = 19'd7;
    r[2*BW +: BW] = 19'h7FFFB;
    r[5*BW +: BW] = 19'h7FFFF;
    rexp = r;
`ifdef OFIFO_RELU_EN
    rexp[2*BW +: BW] = '0;
    rexp[5*BW +: BW] = '0;
`endif
    wr = '1; in = r; step(); wr = '0;
    rd = 1'b1; exp_q.push_back(rexp); step(); rd = 1'b0;
    step(); step();
    chk("out_holds", out, rexp);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rows_missing actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
